run_length_detector: RTL
========================

# run_length_detector

Multi-channel, parametrised run-length detector: flags when RUN_LEN consecutive qualified bits equal to TARGET_BIT arrive on any of CHANNELS independent serial inputs. It supports run-time overlapping and non-overlapping modes, Mealy or Moore output timing, and optional per-channel saturating hit counters. It sits in the FSM library as the general replacement for fixed-length, single-channel consecutive-ones detectors, and feeds framing, sync-word and glitch monitors.

## Interface
- CHANNELS, 4, number of independent serial channels (1..32)
- RUN_LEN, 3, run length to detect (2..255)
- TARGET_BIT, 1'b1, bit value that forms the run
- MEALY, 1, 1 = combinational (Mealy) hit, 0 = registered (Moore) hit
- CNT_W, 8, hit counter width per channel
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- din  input  CHANNELS  serial data, bit i = channel i
- din_vld  input  CHANNELS  per-channel qualifier; a bit is consumed only when set
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; global
- clr  input  1  synchronous clear of run state and hit counters
- hit  output  CHANNELS  detection pulse per channel
- hit_cnt  output  CHANNELS*CNT_W  packed saturating hit counts, channel i at [i*CNT_W +: CNT_W]

## Operation
- Per channel state: run counter `run` of width $clog2(RUN_LEN), range 0..RUN_LEN-1. It holds the number of consecutive matching bits already accepted, capped at RUN_LEN-1.
- match = din[i] == TARGET_BIT. det = din_vld[i] && match && run == RUN_LEN-1.
- The next-state priority is as follows; the first matching rule wins:
  - clr: run <= 0.
  - !din_vld[i]: run holds; invalid cycles neither break nor extend a run.
  - din_vld[i] && !match: run <= 0.
  - det && overlap: run stays RUN_LEN-1, so each further matching bit fires again.
  - det && !overlap: run <= 0, so the next detection needs RUN_LEN fresh bits.
  - Otherwise: run <= run + 1.
- Hit output:
  - MEALY=1: hit[i] = det && !clr, combinational in the cycle the completing bit is presented.
  - MEALY=0: hit[i] is a register loaded with det && !clr, so it is high in the cycle after the completing bit.
- An overlap change takes effect on the next accepted bit. run is not cleared by a mode change.
- Channels are fully independent. Simultaneous hits on several channels are all reported.
- Reset values: run = 0 and hit = 0 on all channels; hit_cnt = 0.

## Timing
- Mealy latency is 0 cycles from the completing bit. Moore latency is 1 cycle. Every hit is a single-cycle pulse per detection.
- Overlap mode with a continuous matching stream gives hit high every accepted bit from bit RUN_LEN onward.
- Non-overlap mode with the same stream gives hit on bits RUN_LEN, 2*RUN_LEN, and so on.
- clr in the same cycle as a completing bit suppresses the hit and the count increment.
- Reset asserted mid-run clears everything immediately. After reset deasserts, the first hit needs a full RUN_LEN bits.
- hit_cnt updates at the clock edge following a det, in both MEALY settings.

## Configuration
- RUN_DET_HIT_COUNT_EN defined:
  - Each channel has a CNT_W-bit counter. It increments on every det unless clr is set.
  - The counter saturates at 2^CNT_W-1. It is cleared by clr or reset.
- RUN_DET_HIT_COUNT_EN undefined:
  - No counter flops are built. hit_cnt stays on the port and is driven constant 0.
  - Detection behaviour is unchanged.

## Structure
- Package run_det_pkg holds:
  - the parameter limits (MAX_CHANNELS=32, MAX_RUN_LEN=255);
  - the function clog2_min1;
  - typedef run_cnt_t for the run counter.
- Sub-module run_det_channel contains one channel's run counter, its det/hit logic and its optional counter.
- The top level generate-loops run_det_channel CHANNELS times and packs hit_cnt.

## Test plan
- RUN_LEN=3, MEALY=1, overlap=1, ch0 din = 1,1,1,1,1,0 all valid -> hit[0] high on bits 3, 4 and 5, low elsewhere; hit_cnt[0] = 3.
- Same stream with overlap=0 -> hit[0] high on bit 3 only; a subsequent 1,1,1 gives a hit on its third bit; hit_cnt[0] = 2.
- MEALY=0, stream 1,1,1 -> hit[0] asserted one cycle after the third bit and for exactly one cycle.
- ch1 din = 1,1,(din_vld=0 for 2 cycles, din=0),1 -> hit[1] on the final bit, because invalid cycles do not break the run. ch2 receives 1,1,0,1 -> no hit.
- Assert reset low after two 1s, release, then send 1 -> no hit, run restarts and hit = 0 throughout reset. Assert clr with a completing bit -> no hit and hit_cnt unchanged.
- CNT_W=2 with 5 overlapping detections -> hit_cnt saturates at 3. With RUN_DET_HIT_COUNT_EN undefined -> hit_cnt = 0 always and hits are identical to the counted build.

Source files
------------

// File: rtl/run_det_pkg.sv
// run_det_pkg: shared limits, width helper and run-counter type for the
// run-length detector.
package run_det_pkg;

  localparam int MAX_CHANNELS = 32;
  localparam int MAX_RUN_LEN  = 255;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < n) w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

  localparam int RUN_W_MAX = clog2_min1(MAX_RUN_LEN);

  // Wide enough for any legal run counter; channels slice it down.
  typedef logic [RUN_W_MAX-1:0] run_cnt_t;

endpackage

// File: rtl/run_det_channel.sv
// run_det_channel: one serial channel of the run-length detector.
// The run counter, the det/hit logic and, when RUN_DET_HIT_COUNT_EN is
// defined, a saturating hit counter.
module run_det_channel
  import run_det_pkg::*;
#(
  parameter int   RUN_LEN    = 3,
  parameter logic TARGET_BIT = 1'b1,
  parameter bit   MEALY      = 1'b1,
  parameter int   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_vld,
  input  logic             overlap,
  input  logic             clr,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int          RW       = clog2_min1(RUN_LEN);
  localparam run_cnt_t    RUN_FULL = run_cnt_t'(RUN_LEN - 1);
  localparam logic [RW-1:0] RUN_LAST = RUN_FULL[RW-1:0];

  logic [RW-1:0] run;
  logic          match;
  logic          det;

  assign match = (din == TARGET_BIT);
  assign det   = din_vld && match && (run == RUN_LAST);

  // Run counter: consecutive accepted matching bits, capped at RUN_LEN-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run <= '0;
    end else if (clr) begin
      run <= '0;
    end else if (!din_vld) begin
      run <= run;
    end else if (!match) begin
      run <= '0;
    end else if (det) begin
      run <= overlap ? RUN_LAST : '0;
    end else begin
      run <= run + 1'b1;
    end
  end

  generate
    if (MEALY) begin : g_mealy
      assign hit = det && !clr;
    end else begin : g_moore
      logic hit_p1;
      // Stage 1: registered hit, one cycle after the completing bit.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) hit_p1 <= 1'b0;
        else        hit_p1 <= det && !clr;
      end
      assign hit = hit_p1;
    end
  endgenerate

`ifdef RUN_DET_HIT_COUNT_EN
  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] cnt_p1;

  // Stage 1: saturating count of detections, cleared by clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt_p1 <= '0;
    else if (clr) cnt_p1 <= '0;
    else if (det) cnt_p1 <= sat_inc(cnt_p1);
  end

  assign hit_cnt = cnt_p1;
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: rtl/run_length_detector.sv
// run_length_detector: CHANNELS independent run-length detectors sharing
// the overlap mode and clear. Optional hit counters: RUN_DET_HIT_COUNT_EN.
module run_length_detector
  import run_det_pkg::*;
#(
  parameter int   CHANNELS   = 4,
  parameter int   RUN_LEN    = 3,
  parameter logic TARGET_BIT = 1'b1,
  parameter bit   MEALY      = 1'b1,
  parameter int   CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       din,
  input  logic [CHANNELS-1:0]       din_vld,
  input  logic                      overlap,
  input  logic                      clr,
  output logic [CHANNELS-1:0]       hit,
  output logic [CHANNELS*CNT_W-1:0] hit_cnt
);

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      run_det_channel #(
        .RUN_LEN   (RUN_LEN),
        .TARGET_BIT(TARGET_BIT),
        .MEALY     (MEALY),
        .CNT_W     (CNT_W)
      ) u_ch (
        .clk    (clk),
        .reset  (reset),
        .din    (din[i]),
        .din_vld(din_vld[i]),
        .overlap(overlap),
        .clr    (clr),
        .hit    (hit[i]),
        .hit_cnt(hit_cnt[i*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule
